// File: rtl/idu_lane_decoder_if.sv
// Command-side bundle for idu_lane_decoder: arm/stall controls, command handshake and lane bank.
// The decoder takes the slave modport; the command source takes the master modport.
interface idu_lane_decoder_if #(
    parameter int BYTES    = 6,
    parameter int COLS_PER = 2,
    parameter int ROWS_PER = 2
);
    localparam int W     = 8 * BYTES;
    localparam int LANES = COLS_PER * ROWS_PER;
    localparam int DW    = LANES * W;

    logic          init;
    logic          cts;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    CMD;
    logic [7:0]    Operand_ID;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          armed;

    modport slave (
        input  init, cts, cmd_valid, CMD, Operand_ID, data_in,
        output cmd_ready, data_out, out_valid, armed
    );

    modport master (
        output init, cts, cmd_valid, CMD, Operand_ID, data_in,
        input  cmd_ready, data_out, out_valid, armed
    );
endinterface

// File: rtl/idu_lane_decoder.sv
// Lane decoder: Immediate/Fill/Row/Column writes into a registered lane bank; IDU_SAVE_RESTORE_EN adds a shadow bank.
// Latency: out_valid pulses the cycle after the single EXEC cycle that follows the handshake.
// Backpressure: cmd_ready low while unarmed, during the CTS stall window, in EXEC, or while init is high.
module idu_lane_decoder #(
    parameter int BYTES      = 6,
    parameter int COLS_PER   = 2,
    parameter int ROWS_PER   = 2,
    parameter int ROW        = 0,
    parameter int COLUMN     = 0,
    parameter int ARM_CYCLES = 15,
    parameter int CTS_CYCLES = 15
) (
    input  logic sys_clk,
    input  logic sys_reset,
    idu_lane_decoder_if.slave bus
);
    localparam int W     = 8 * BYTES;
    localparam int LANES = COLS_PER * ROWS_PER;
    localparam int DW    = LANES * W;

    typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_EXEC} state_e;

    state_e        state_q, state_d;
    logic [7:0]    arm_cnt_q, arm_cnt_d;
    logic [7:0]    cts_cnt_q, cts_cnt_d;
    logic          armed_q, armed_d;
    logic [3:0]    cmd_q;
    logic [7:0]    opnd_q;
    logic [DW-1:0] data_q, data_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] exec_res;
    logic          hs;
    logic          exec_ok;
`ifdef IDU_SAVE_RESTORE_EN
    logic [DW-1:0] shadow_q;
`endif

    assign bus.cmd_ready = armed_q & (cts_cnt_q == 8'd0) & (state_q == ST_IDLE) & ~bus.init;
    assign hs            = bus.cmd_valid & bus.cmd_ready;
    assign exec_ok       = (state_q == ST_EXEC) & ~bus.init;
    assign bus.data_out  = data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.armed     = armed_q;

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        cts_cnt_d = cts_cnt_q;
        if (bus.init) begin
            arm_cnt_d = 8'(ARM_CYCLES);
        end else if (arm_cnt_q != 8'd0) begin
            arm_cnt_d = arm_cnt_q - 8'd1;
        end
        if (bus.cts) begin
            cts_cnt_d = 8'(CTS_CYCLES);
        end else if (cts_cnt_q != 8'd0) begin
            cts_cnt_d = cts_cnt_q - 8'd1;
        end
        armed_d = (arm_cnt_q == 8'd0) & ~bus.init;
    end

    // Leave ARM on the same edge armed rises so cmd_ready follows armed without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM:  if (armed_d) state_d = ST_IDLE;
            ST_IDLE: if (hs)      state_d = ST_EXEC;
            ST_EXEC:              state_d = ST_IDLE;
            default:              state_d = ST_ARM;
        endcase
        if (bus.init) state_d = ST_ARM;
    end

    always_comb begin
        exec_res = data_q;
        if (cmd_q[3:2] == 2'b01) begin
            exec_res = bus.data_in;
        end else begin
            case (cmd_q)
                4'b1000: exec_res = {(LANES * BYTES){opnd_q}};
                4'b1010: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (5'(ROW + l / COLS_PER) == opnd_q[7:3]) begin
                            for (int b = 0; b < BYTES; b++) begin
                                exec_res[l*W + b*8 +: 8] = bus.data_in[7:0];
                            end
                        end
                    end
                end
                4'b1011: begin
                    for (int l = 0; l < LANES; l++) begin
                        if ((3'(COLUMN + l % COLS_PER) == opnd_q[2:0]) &&
                            (int'(opnd_q[7:5]) < BYTES)) begin
                            exec_res[l*W + int'(opnd_q[7:5])*8 +: 8] = bus.data_in[7:0];
                        end
                    end
                end
`ifdef IDU_SAVE_RESTORE_EN
                4'b1101: exec_res = shadow_q;
`endif
                default: exec_res = data_q;
            endcase
        end
        data_d      = exec_ok ? exec_res : data_q;
        out_valid_d = exec_ok;
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q     <= ST_ARM;
            arm_cnt_q   <= 8'(ARM_CYCLES);
            cts_cnt_q   <= 8'd0;
            armed_q     <= 1'b0;
            cmd_q       <= 4'd0;
            opnd_q      <= 8'd0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            cts_cnt_q   <= cts_cnt_d;
            armed_q     <= armed_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            if (hs) begin
                cmd_q  <= bus.CMD;
                opnd_q <= bus.Operand_ID;
            end
        end
    end

`ifdef IDU_SAVE_RESTORE_EN
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            shadow_q <= '0;
        end else if (exec_ok && (cmd_q == 4'b1100)) begin
            shadow_q <= data_q;
        end
    end
`endif
endmodule

// File: tb/tb_idu_lane_decoder.sv
// Directed bench for idu_lane_decoder: expected lane banks are queued at issue and checked by a monitor on out_valid.
module tb_idu_lane_decoder;
    localparam logic [47:0]  LA = 48'hA5A5A5A5A5A5;
    localparam logic [47:0]  LC = 48'hA5A53CA5A5A5;
    localparam logic [47:0]  LR = 48'h7E7E7E7E7E7E;
    localparam logic [191:0] E_FILL = {LA, LA, LA, LA};
    localparam logic [191:0] E_COL  = {LC, LA, LC, LA};
    localparam logic [191:0] E_ROW  = {LR, LR, LC, LA};
    localparam logic [191:0] D1 = 192'h123456789ABCDEF0_0FEDCBA987654321_1122334455667788;
    localparam logic [191:0] D2 = 192'hEDCBA9876543210F_F0123456789ABCDE_EEDDCCBBAA998877;
    localparam logic [191:0] JUNK = {{23{8'h11}}, 8'h00};

    logic sys_clk;
    logic sys_reset;
    int   tests;
    int   fails;
    logic [191:0] exp_q[$];

    idu_lane_decoder_if #(.BYTES(6), .COLS_PER(2), .ROWS_PER(2)) bus ();

    idu_lane_decoder dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one command from a negedge; returns at the negedge of the out_valid cycle.
    task automatic send(input logic [3:0] c, input logic [7:0] op,
                        input logic [191:0] din, input logic [191:0] exp);
        int n;
        n = 0;
        bus.CMD        = c;
        bus.Operand_ID = op;
        bus.data_in    = din;
        bus.cmd_valid  = 1'b1;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: got cmd_ready=0 expected 1 within 100 cycles");
            bus.cmd_valid = 1'b0;
        end else begin
            exp_q.push_back(exp);
            @(posedge sys_clk);
            @(negedge sys_clk);
            bus.cmd_valid = 1'b0;
            check("out_valid_in_exec", 192'(bus.out_valid), 192'd0);
            @(negedge sys_clk);
            check("out_valid_latency", 192'(bus.out_valid), 192'd1);
        end
    endtask

    task automatic wait_armed(input string nm);
        int n;
        n = 0;
        while (!bus.armed && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        check(nm, 192'(n), 192'd16);
        check({nm, "_ready"}, 192'(bus.cmd_ready), 192'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sys_reset      = 1'b1;
        bus.init       = 1'b0;
        bus.cts        = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.CMD        = 4'd0;
        bus.Operand_ID = 8'd0;
        bus.data_in    = '0;

        fork
            forever begin
                @(negedge sys_clk);
                if (!sys_reset && bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out_valid: got out_valid=1 expected 0");
                    end else begin
                        check("data_out", bus.data_out, exp_q.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(negedge sys_clk);
        check("reset_data_out", bus.data_out, 192'd0);
        check("reset_out_valid", 192'(bus.out_valid), 192'd0);
        check("reset_armed", 192'(bus.armed), 192'd0);
        check("reset_cmd_ready", 192'(bus.cmd_ready), 192'd0);

        sys_reset = 1'b0;
        bus.init  = 1'b1;
        @(negedge sys_clk);
        bus.init  = 1'b0;
        wait_armed("arm_latency");
        check("armed_data_out", bus.data_out, 192'd0);

        send(4'b1000, 8'hA5, JUNK, E_FILL);
        send(4'b1011, 8'h61, JUNK | 192'h3C, E_COL);
        send(4'b1011, 8'hC1, JUNK | 192'h3C, E_COL);
        send(4'b1010, 8'h08, JUNK | 192'h7E, E_ROW);
        send(4'b0001, 8'hFF, D1, E_ROW);

        // CTS stall, then abort the held command with init during its EXEC cycle.
        bus.cts = 1'b1;
        @(negedge sys_clk);
        bus.cts        = 1'b0;
        bus.CMD        = 4'b1000;
        bus.Operand_ID = 8'h5A;
        bus.cmd_valid  = 1'b1;
        begin
            int n;
            n = 0;
            while (!bus.cmd_ready && n < 40) begin
                n++;
                @(negedge sys_clk);
            end
            check("cts_stall_cycles", 192'(n), 192'd15);
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        bus.init      = 1'b1;
        @(negedge sys_clk);
        check("abort_out_valid", 192'(bus.out_valid), 192'd0);
        check("abort_armed", 192'(bus.armed), 192'd0);
        check("abort_data_out", bus.data_out, E_ROW);
        check("init_blocks_ready", 192'(bus.cmd_ready), 192'd0);
        bus.init = 1'b0;
        wait_armed("rearm_latency");

        send(4'b0100, 8'h00, D1, D1);
        send(4'b1100, 8'h00, D2, D1);
        send(4'b1000, 8'h00, D2, 192'd0);
`ifdef IDU_SAVE_RESTORE_EN
        send(4'b1101, 8'h00, D2, D1);
`else
        send(4'b1101, 8'h00, D2, 192'd0);
`endif
        send(4'b0111, 8'h00, D2, D2);

        repeat (3) @(negedge sys_clk);
        check("scoreboard_drained", 192'(exp_q.size()), 192'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/idu_lane_decoder.md
Name: idu_lane_decoder

Overview:
Parametrised successor to the per-tile instruction decoder unit. Decodes CMD/Operand_ID into Immediate, Fill, Row and Column writes across a configurable grid of byte lanes, and holds the result in a registered output bank. Adds a valid/ready command handshake, a level "armed" window after init, and a CTS stall window. Sits between the command broadcast bus and the tile datapath. One instance covers a ROWS_PER x COLS_PER sub-grid of tiles.

Parameters:
BYTES, 6, bytes per lane; lane width W = 8*BYTES.
COLS_PER, 2, lane columns per instance.
ROWS_PER, 2, lane rows per instance; LANES = COLS_PER*ROWS_PER.
ROW, 0, 5-bit base row ID of lane 0.
COLUMN, 0, 3-bit base column ID of lane 0.
ARM_CYCLES, 15, countdown length after init (range 2..255).
CTS_CYCLES, 15, stall length after CTS (range 1..255).

Ports:
sys_clk  in  1  clock, rising edge.
sys_reset  in  1  asynchronous, active-high reset.
init  in  1  re-arm request; level, restarts arm countdown.
cts  in  1  clear-to-send pulse; starts stall window.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
CMD  in  4  opcode.
Operand_ID  in  8  operand: fill byte, or {row[7:3]}, or {pos[7:5], col[2:0]}.
data_in  in  LANES*W  immediate / source data; byte data_in[7:0] is the row/column payload.
data_out  out  LANES*W  registered lane bank; lane l at [l*W +: W].
out_valid  out  1  one-cycle pulse when data_out updated by a command.
armed  out  1  decoder enabled.

Behaviour:
- Lane mapping: lane l has row ID ROW + l/COLS_PER and column ID COLUMN + l%COLS_PER (unsigned, compared at 5 and 3 bits respectively, wrap modulo field width).
- Arm counter (8b): reset and init load ARM_CYCLES; decrements to 0 and holds. armed registered = (counter==0) & ~init; it rises exactly ARM_CYCLES+1 cycles after the last cycle init was high. init asserted drops armed the next cycle.
- CTS counter (8b): reset 0; cts loads CTS_CYCLES; decrements to 0. cts and init in the same cycle: both counters load.
- cmd_ready = armed & (cts_count==0) & (state==IDLE) & ~init (combinational).
- FSM: ARM (armed low) -> IDLE when armed rises; IDLE -> EXEC on handshake; EXEC -> IDLE after 1 cycle; any state -> ARM on init. Command fields are captured at handshake; data_in is sampled in the EXEC cycle (source must hold it stable one cycle past the handshake).
- EXEC computes next data_out from current data_out (read-modify-write), written at the end of EXEC. out_valid is high the cycle after EXEC, i.e. 2 cycles after the handshake edge.
  - CMD 0100..0111 (Immediate): data_out <= data_in, all lanes.
  - CMD 1000 (Fill): every byte of every lane <= Operand_ID.
  - CMD 1010 (Row): lanes whose row ID == Operand_ID[7:3]: every byte <= data_in[7:0]; other lanes unchanged.
  - CMD 1011 (Column): lanes whose column ID == Operand_ID[2:0]: byte index pos=Operand_ID[7:5] (byte 0 = LSB) <= data_in[7:0]; pos >= BYTES: no write. Every pos < BYTES maps to its own byte.
  - Any other CMD: accepted, data_out unchanged, out_valid still pulses.
- init during EXEC: the write is aborted, data_out holds its prior value, no out_valid.
- Reset: data_out 0, out_valid 0, armed 0, cmd_ready 0, state ARM, arm counter ARM_CYCLES, CTS counter 0. Reset mid-operation discards the in-flight command.

Optional Feature:
IDU_SAVE_RESTORE_EN: when defined, a LANES*W shadow register (reset 0) is added. CMD 1100 copies data_out to the shadow. CMD 1101 copies the shadow to data_out. Both take the normal EXEC/out_valid timing. When undefined, 1100/1101 are treated as NOP and there is no shadow storage.

Test Plan:
- Reset release, init high 1 cycle, ARM_CYCLES=15 -> armed and cmd_ready rise 16 cycles after init falls; data_out=0.
- Fill with Operand_ID=8'hA5 -> out_valid 2 cycles after the handshake; all 192 bits = {24{8'hA5}}.
- Default ROW=0, COLUMN=0, Column CMD with Operand_ID={3'd3,5'd1}, data_in[7:0]=8'h3C -> lanes 1 and 3 byte 3 = 8'h3C; lanes 0 and 2 unchanged. Repeat with pos=6 -> no change, out_valid pulses.
- Row CMD with Operand_ID[7:3]=1, data_in[7:0]=8'h7E -> lanes 2 and 3 = {6{8'h7E}}; lanes 0 and 1 unchanged.
- cts pulse then cmd_valid held -> cmd_ready low 15 cycles; accepted on the 16th; init asserted in EXEC -> data_out unchanged, armed drops, no out_valid.
- With IDU_SAVE_RESTORE_EN: Immediate 192'h1234..., then save, then Fill 8'h00, then restore -> data_out returns to the immediate value.
